// File: rtl/imem_loader.sv
// Streams a program into instruction memory: gathers bytes into big-endian words,
// writes them at consecutive word addresses and holds the core in reset until done.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [1:0]        idx_q, idx_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              error_q, error_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      idx_q       <= '0;
      cpu_reset_q <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      idx_q       <= idx_d;
      cpu_reset_q <= cpu_reset_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    idx_d       = idx_q;
    cpu_reset_d = cpu_reset_q;
    error_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((word_count != '0) && (word_count <= MAX_WORDS)) begin
            state_d     = RECV;
            remaining_d = word_count;
            addr_d      = '0;
            idx_d       = '0;
            cpu_reset_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (byte_valid) begin
          wd_d  = {wd_q[23:0], byte_data};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        remaining_d = remaining_q - (ADDR_W+1)'(1);
        // The final word leaves the address on the last slot so a full load never wraps.
        if (remaining_q == (ADDR_W+1)'(1)) begin
          state_d     = DONE;
          cpu_reset_d = 1'b0;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RECV;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign byte_ready = (state_q == RECV);
  assign imem_we    = (state_q == WRITE);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign imem_addr  = addr_q;
  assign imem_wd    = wd_q;
  assign cpu_reset  = cpu_reset_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random programs streamed in, writes captured
// by a monitor and compared against the words the bench itself generated.
module tb_imem_loader;

  logic        clk;
  logic        Reset;
  logic        start;
  logic [8:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] stim_words[$];
  logic [39:0] got[$];
  int done_cnt, err_cnt, busy_cnt, bad_ready, bad_busy, bad_cpu;
  int last_we_cyc, done_cyc, hs_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every write and flag protocol violations at the negedge.
  always @(negedge clk) begin
    if (!Reset) begin
      if (imem_we) begin
        got.push_back({imem_addr, imem_wd});
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (error) err_cnt++;
      if (busy) busy_cnt++;
      if (imem_we && byte_ready) bad_ready++;
      if ((imem_we || byte_ready) && !busy) bad_busy++;
      if ((busy && !cpu_reset) || (done && cpu_reset)) bad_cpu++;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic clear_monitor();
    got.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    bad_ready = 0; bad_busy = 0; bad_cpu = 0;
    last_we_cyc = -1; done_cyc = -1; hs_cyc = -1;
  endtask

  task automatic fill_random(input int n);
    stim_words.delete();
    for (int i = 0; i < n; i++) stim_words.push_back($urandom);
  endtask

  // gap_mode: 0 back-to-back, 1 toggling valid, 2 random valid; noise drives start randomly.
  task automatic apply_stimulus(input int n, input int gap_mode, input bit noise);
    bit xfer;
    bit timeout;
    int budget;
    clear_monitor();
    timeout = 1'b0;
    byte_valid = 1'b0;
    word_count = 9'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        xfer = 1'b0;
        budget = 0;
        while (!xfer && budget < 200) begin
          case (gap_mode)
            0:       byte_valid = 1'b1;
            1:       byte_valid = ~byte_valid;
            default: byte_valid = 1'($urandom_range(0, 1));
          endcase
          byte_data = byte_valid ? stim_words[w][31-8*b -: 8] : 8'($urandom);
          if (noise) begin
            start = 1'($urandom);
            word_count = 9'($urandom);
          end
          @(negedge clk);
          xfer = byte_valid && byte_ready;
          hs_cyc = cyc;
          @(posedge clk); #1;
          budget++;
        end
        if (!xfer) timeout = 1'b1;
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 10 && done_cnt == 0; k++) @(negedge clk);
    @(negedge clk);
    check_output("load_timeout", 64'(timeout), 64'd0);
    check_output("write_count", 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check_output($sformatf("write[%0d]", i), 64'(got[i]), 64'({8'(i), stim_words[i]}));
    check_output("done_pulses", 64'(done_cnt), 64'd1);
    check_output("error_pulses", 64'(err_cnt), 64'd0);
    check_output("ready_during_write", 64'(bad_ready), 64'd0);
    check_output("busy_coverage", 64'(bad_busy), 64'd0);
    check_output("cpu_reset_timing", 64'(bad_cpu), 64'd0);
    check_output("write_latency", 64'(last_we_cyc), 64'(hs_cyc + 1));
    check_output("done_latency", 64'(done_cyc), 64'(last_we_cyc + 1));
    check_output("idle_cpu_reset", 64'(cpu_reset), 64'd0);
    check_output("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = '0;
    clear_monitor();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_byte_ready", 64'(byte_ready), 64'd0);
    check_output("rst_imem_we", 64'(imem_we), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_error", 64'(error), 64'd0);
    check_output("rst_addr", 64'(imem_addr), 64'd0);
    check_output("rst_wd", 64'(imem_wd), 64'd0);
    check_output("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    @(posedge clk); #1;
    Reset = 1'b0;

    // Single directed word.
    stim_words.delete();
    stim_words.push_back(32'h20080005);
    apply_stimulus(1, 0, 1'b0);

    // Rejected word counts: cpu_reset must stay released from the previous load.
    for (int t = 0; t < 2; t++) begin
      clear_monitor();
      word_count = (t == 0) ? 9'd0 : 9'd257;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_output($sformatf("bad_count_error[%0d]", t), 64'(err_cnt), 64'd1);
      check_output($sformatf("bad_count_writes[%0d]", t), 64'(got.size()), 64'd0);
      check_output($sformatf("bad_count_busy[%0d]", t), 64'(busy_cnt), 64'd0);
      check_output($sformatf("bad_count_cpu_reset[%0d]", t), 64'(cpu_reset), 64'd0);
      @(posedge clk); #1;
    end

    // Three words with byte_valid toggling.
    fill_random(3);
    apply_stimulus(3, 1, 1'b0);

    // Reset after two bytes of the first word.
    clear_monitor();
    word_count = 9'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'hAA;
    @(posedge clk); #1;
    byte_data = 8'hBB;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    check_output("midrst_writes", 64'(got.size()), 64'd0);
    check_output("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
    check_output("midrst_busy", 64'(busy), 64'd0);
    check_output("midrst_wd", 64'(imem_wd), 64'd0);
    check_output("midrst_addr", 64'(imem_addr), 64'd0);
    @(posedge clk); #1;
    fill_random(3);
    apply_stimulus(3, 0, 1'b0);

    // Full-depth load with random gaps.
    fill_random(256);
    apply_stimulus(256, 2, 1'b0);

    // Spurious start pulses while loading.
    fill_random(5);
    apply_stimulus(5, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
